pulse_stretcher: RTL and testbench

Turns single-cycle event pulses into timed, human-visible level windows, converting pulse back to level. The synchronizer front end does the opposite, turning a level into a pulse. In the parking meter it sits between the control FSM and the buzzer/LED outputs. Each request pulse (coin accepted, time expired, invalid key) produces exactly one ON window followed by a mandatory OFF gap. Requests that arrive while a window is in progress are counted and replayed in order, so no event is lost until the pending counter saturates.

---
 rtl/parking_pkg.sv | 22 ++
 rtl/pulse_stretcher.sv | 139 +++++++++++++
 tb/tb_pulse_stretcher.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/parking_pkg.sv
// parking_pkg
//   Shared definitions for the parking meter blocks.
//   - ps_state_t  : state encoding of the pulse stretcher FSM
//   - DEF_*       : default timing constants used by the meter's top level
//   - max2        : small constant helper for sizing counters
package parking_pkg;

  typedef enum logic [1:0] {
    PS_IDLE = 2'd0,
    PS_ON   = 2'd1,
    PS_GAP  = 2'd2
  } ps_state_t;

  localparam int DEF_ON_CYCLES  = 4;
  localparam int DEF_GAP_CYCLES = 2;
  localparam int DEF_PEND_W     = 3;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_stretcher.sv
// pulse_stretcher
//   Turns single-cycle request pulses into ON windows of ON_CYCLES clocks,
//   each followed by a forced low gap of GAP_CYCLES clocks. Requests that
//   arrive while a window is running are counted and replayed in order; once
//   the pending counter is full, further requests are dropped and flagged.
//
// Parameters
//   ON_CYCLES  : length of each high window (>= 1)
//   GAP_CYCLES : forced low gap after each window (>= 1)
//   PEND_W     : width of the pending counter (queue depth 2^PEND_W - 1)
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-high reset
//   pulse_in  in   request strobe, one request per high cycle
//   level_out out  high during ON windows
//   busy      out  high whenever the FSM is not idle
//   pending   out  queued requests not yet started
//   overflow  out  one-cycle strobe when a request is dropped
module pulse_stretcher
  import parking_pkg::*;
#(
  parameter int ON_CYCLES  = DEF_ON_CYCLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int PEND_W     = DEF_PEND_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int CNT_W = $clog2(max2(ON_CYCLES, GAP_CYCLES)) + 1;

  localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYCLES);
  localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  ps_state_t         state;
  ps_state_t         state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [PEND_W-1:0] pending_next;

  logic start_eval;
  logic start;
  logic queued;
  logic enq;
  logic deq;
  logic drop;

  // Next-state and timer. A start decision is taken either from IDLE or on
  // the last GAP cycle, so back-to-back windows run without an idle cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    start_eval = 1'b0;

    case (state)
      PS_IDLE: begin
        start_eval = 1'b1;
      end
      PS_ON: begin
        if (cnt == CNT_ONE) begin
          state_next = PS_GAP;
          cnt_next   = GAP_LOAD;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      PS_GAP: begin
        if (cnt == CNT_ONE) begin
          start_eval = 1'b1;
        end else begin
          cnt_next = cnt - CNT_ONE;
        end
      end
      default: begin
        state_next = PS_IDLE;
        cnt_next   = '0;
      end
    endcase

    queued = (pending != '0);
    start  = start_eval && (pulse_in || queued);

    if (start_eval) begin
      if (start) begin
        state_next = PS_ON;
        cnt_next   = ON_LOAD;
      end else begin
        state_next = PS_IDLE;
        cnt_next   = '0;
      end
    end
  end

  // Pending queue bookkeeping. A start with a non-empty queue serves the
  // oldest queued request, so a pulse in that same cycle must be queued;
  // only a start from an empty queue consumes the pulse directly.
  always_comb begin
    deq  = start && queued;
    enq  = pulse_in && !(start && !queued);
    drop = enq && !deq && (pending == PEND_MAX);

    pending_next = pending;
    case ({enq, deq})
      2'b10:   pending_next = drop ? pending : pending + PEND_ONE;
      2'b01:   pending_next = pending - PEND_ONE;
      default: pending_next = pending;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with
  // the state they describe and never depend combinationally on pulse_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PS_IDLE;
      cnt       <= '0;
      pending   <= '0;
      level_out <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      pending   <= pending_next;
      level_out <= (state_next == PS_ON);
      busy      <= (state_next != PS_IDLE);
      overflow  <= drop;
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher
//   Directed scenarios for pulse_stretcher with ON=4, GAP=2, PEND_W=3.
//   Cycle k is the interval following rising edge k of a scenario; inputs
//   for cycle k are driven just after that edge and outputs are sampled on
//   the falling edge inside the same cycle.
module tb_pulse_stretcher;

  localparam int ON_C  = 4;
  localparam int GAP_C = 2;
  localparam int PW    = 3;
  localparam int LEN   = 76;

  typedef struct {
    int       cyc;
    logic     level;
    logic     busy;
    int       pend;
    logic     ovf;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          pulse_in;
  logic          level_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  exp_t expQ[$];

  logic   expLevel[LEN];
  logic   expBusy[LEN];
  logic   expOvf[LEN];
  int     expPend[LEN];
  int     expWindows;
  logic [127:0] pulseMask;
  logic [127:0] rstMask;

  int     checks;
  int     errors;
  int     riseCount;
  logic   prevLevel;
  string  scenName;

  pulse_stretcher #(
    .ON_CYCLES (ON_C),
    .GAP_CYCLES(GAP_C),
    .PEND_W    (PW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pulse_in (pulse_in),
    .level_out(level_out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison, counted, with a FAIL line on mismatch.
  task automatic checkOutput(input string name, input int c,
                             input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s %s cycle %0d: got %0d, expected %0d",
               scenName, name, c, act, exp);
    end
  endtask

  // Monitor: pops the expectation queued for the current cycle and compares
  // every output against it; also counts windows by rising edges.
  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      if (e.cyc == 0) begin
        riseCount = 0;
        prevLevel = 1'b0;
      end
      if (level_out === 1'b1 && prevLevel === 1'b0) riseCount++;
      prevLevel = level_out;
      checkOutput("level_out", e.cyc, {7'd0, level_out}, {7'd0, e.level});
      checkOutput("busy",      e.cyc, {7'd0, busy},      {7'd0, e.busy});
      checkOutput("pending",   e.cyc, {5'd0, pending},   8'(e.pend));
      checkOutput("overflow",  e.cyc, {7'd0, overflow},  {7'd0, e.ovf});
    end
  end

  // Helpers for writing hand-computed expectation tables.
  task automatic clearExpect();
    for (int i = 0; i < LEN; i++) begin
      expLevel[i] = 1'b0;
      expBusy[i]  = 1'b0;
      expOvf[i]   = 1'b0;
      expPend[i]  = 0;
    end
    expWindows = 0;
    pulseMask  = '0;
    rstMask    = '0;
  endtask

  task automatic addWindow(input int s);
    for (int i = 0; i < ON_C + GAP_C; i++) begin
      if (s + i < LEN) begin
        expBusy[s + i] = 1'b1;
        if (i < ON_C) expLevel[s + i] = 1'b1;
      end
    end
    expWindows++;
  endtask

  task automatic addPend(input int c, input int v);
    for (int i = c; i < LEN; i++) expPend[i] = v;
  endtask

  task automatic addOvf(input int c);
    expOvf[c] = 1'b1;
  endtask

  task automatic clearFrom(input int c);
    for (int i = c; i < LEN; i++) begin
      expLevel[i] = 1'b0;
      expBusy[i]  = 1'b0;
      expOvf[i]   = 1'b0;
    end
  endtask

  task automatic setPulses(input int first, input int last);
    for (int i = first; i <= last; i++) pulseMask[i] = 1'b1;
  endtask

  // Resets the DUT, then drives LEN cycles from the masks while queueing
  // that cycle's expectation for the monitor; finally checks window count.
  task automatic applyStimulus(input string name);
    exp_t e;
    scenName = name;
    rst      = 1'b1;
    pulse_in = 1'b0;
    @(posedge clk);
    @(posedge clk);
    for (int k = 0; k < LEN; k++) begin
      if (k > 0) @(posedge clk);
      #1;
      rst      = rstMask[k];
      pulse_in = pulseMask[k];
      e.cyc    = k;
      e.level  = expLevel[k];
      e.busy   = expBusy[k];
      e.pend   = expPend[k];
      e.ovf    = expOvf[k];
      expQ.push_back(e);
    end
    @(posedge clk);
    #1;
    pulse_in = 1'b0;
    checkOutput("windows", LEN, 8'(riseCount), 8'(expWindows));
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    riseCount = 0;
    prevLevel = 1'b0;
    rst      = 1'b1;
    pulse_in = 1'b0;
    scenName = "init";

    // Single pulse from idle.
    clearExpect();
    setPulses(10, 10);
    addWindow(11);
    applyStimulus("single");

    // Three consecutive pulses: two queued, replayed back to back.
    clearExpect();
    setPulses(10, 12);
    addWindow(11); addWindow(17); addWindow(23);
    addPend(12, 1); addPend(13, 2); addPend(17, 1); addPend(23, 0);
    applyStimulus("three");

    // Pulse in the last GAP cycle with an empty queue starts directly.
    clearExpect();
    setPulses(10, 10); setPulses(16, 16);
    addWindow(11); addWindow(17);
    applyStimulus("gapexit");

    // Ten pulses: the pulse at 16 coincides with the first GAP-exit deq and
    // is still queued, so eight requests get queued (nine windows in all)
    // and only the pulse at 19 is dropped.
    clearExpect();
    setPulses(10, 19);
    for (int w = 0; w < 9; w++) addWindow(11 + 6 * w);
    addPend(12, 1); addPend(13, 2); addPend(14, 3); addPend(15, 4);
    addPend(16, 5); addPend(18, 6); addPend(19, 7); addPend(23, 6);
    addPend(29, 5); addPend(35, 4); addPend(41, 3); addPend(47, 2);
    addPend(53, 1); addPend(59, 0);
    addOvf(20);
    applyStimulus("saturate");

    // Reset during the first window with two requests queued.
    clearExpect();
    setPulses(10, 12);
    rstMask[13] = 1'b1;
    addWindow(11);
    addPend(12, 1); addPend(13, 2); addPend(14, 0);
    clearFrom(14);
    expWindows = 1;
    applyStimulus("midreset");

    // Full queue: a pulse at the GAP exit (cycle 22) pairs with the deq.
    clearExpect();
    setPulses(10, 15); setPulses(17, 19); setPulses(22, 22);
    for (int w = 0; w < 10; w++) addWindow(11 + 6 * w);
    addPend(12, 1); addPend(13, 2); addPend(14, 3); addPend(15, 4);
    addPend(16, 5); addPend(17, 4); addPend(18, 5); addPend(19, 6);
    addPend(20, 7); addPend(29, 6); addPend(35, 5); addPend(41, 4);
    addPend(47, 3); addPend(53, 2); addPend(59, 1); addPend(65, 0);
    applyStimulus("fullpair");

    begin
      int waitCnt;
      waitCnt = 0;
      while (expQ.size() != 0 && waitCnt < 5) begin
        @(negedge clk);
        waitCnt++;
      end
      checks++;
      if (expQ.size() != 0) begin
        errors++;
        $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
